// File: rtl/vga_axil_if.sv
// vga_axil_if: AXI-Lite channel bundle between the system initiator and the
// VGA register file. clk/rst are not part of the bundle.
//
// Handshake rule for every channel (AR, R, AW, W, B): a transfer happens on a
// rising clk edge where valid and ready are both high. The source holds its
// payload stable while valid is high and ready is low.
interface vga_axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/vga_axil_regs.sv
// vga_axil_regs: AXI-Lite register file for the VGA controller.
//   0x00 CTRL rw [1:0], 0x04 BG_COLOR rw [11:0], 0x08 FG_COLOR rw [11:0],
//   0x0C STATUS ro [15:0] (frame_cnt_i), 0x10 SCRATCH rw [31:0].
// Independent read and write FSMs, one outstanding transaction each.
// Optional build macro VGA_AXIL_STRB_EN: when defined, wstrb masks bytes of a
// write; when undefined every accepted write replaces the full word.
// dbg_w_state_o / dbg_r_state_o expose the FSM states (1 = response pending).
module vga_axil_regs #(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [11:0] BG_RST = 12'h000,
  parameter logic [11:0] FG_RST = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  vga_axil_if.slave   bus,
  output logic        vga_en_o,
  output logic        vga_pattern_o,
  output logic [11:0] vga_bg_o,
  output logic [11:0] vga_fg_o,
  input  logic [15:0] frame_cnt_i,
  output logic        dbg_w_state_o,
  output logic        dbg_r_state_o
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         STRB_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] MAP_END = ADDR_W'(32'h14);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [11:0]       bg_q, bg_d;
  logic [11:0]       fg_q, fg_d;
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [2:0]        wr_idx, rd_idx;
  logic              wr_in_map, wr_legal, rd_in_map;
  logic [DATA_W-1:0] wr_old, wr_mask, wr_new, rd_value;
  logic [1:0]        rd_resp;

  // Address decode, byte merge of the write target and read-side mux.
  always_comb begin
    wr_idx    = bus.awaddr[4:2];
    wr_in_map = bus.awaddr < MAP_END;
    wr_legal  = wr_in_map && (wr_idx != 3'd3);
    case (wr_idx)
      3'd0:    wr_old = DATA_W'(ctrl_q);
      3'd1:    wr_old = DATA_W'(bg_q);
      3'd2:    wr_old = DATA_W'(fg_q);
      3'd4:    wr_old = scratch_q;
      default: wr_old = '0;
    endcase
    wr_mask = '0;
`ifdef VGA_AXIL_STRB_EN
    for (int b = 0; b < STRB_W; b++) begin
      wr_mask[8*b +: 8] = {8{bus.wstrb[b]}};
    end
`else
    wr_mask = '1;
`endif
    wr_new = (wr_old & ~wr_mask) | (bus.wdata & wr_mask);

    rd_idx    = bus.araddr[4:2];
    rd_in_map = bus.araddr < MAP_END;
    rd_resp   = rd_in_map ? RESP_OKAY : RESP_SLVERR;
    rd_value  = '0;
    if (rd_in_map) begin
      case (rd_idx)
        3'd0:    rd_value = DATA_W'(ctrl_q);
        3'd1:    rd_value = DATA_W'(bg_q);
        3'd2:    rd_value = DATA_W'(fg_q);
        3'd3:    rd_value = DATA_W'(frame_cnt_i);
        3'd4:    rd_value = scratch_q;
        default: rd_value = '0;
      endcase
    end
  end

  // Write FSM: accept AW and W together in one cycle, then hold B until bready.
  always_comb begin
    w_state_d   = w_state_q;
    bresp_d     = bresp_q;
    ctrl_d      = ctrl_q;
    bg_d        = bg_q;
    fg_d        = fg_q;
    scratch_d   = scratch_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && bus.wvalid && !rst) begin
          bus.awready = 1'b1;
          bus.wready  = 1'b1;
          w_state_d   = W_RESP;
          bresp_d     = wr_legal ? RESP_OKAY : RESP_SLVERR;
          if (wr_legal) begin
            case (wr_idx)
              3'd0:    ctrl_d    = wr_new[1:0];
              3'd1:    bg_d      = wr_new[11:0];
              3'd2:    fg_d      = wr_new[11:0];
              3'd4:    scratch_d = wr_new;
              default: ;
            endcase
          end
        end
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: capture data/response on AR accept, then hold R until rready.
  always_comb begin
    r_state_d   = r_state_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid && !rst) begin
          bus.arready = 1'b1;
          rdata_d     = rd_value;
          rresp_d     = rd_resp;
          r_state_d   = R_RESP;
        end
      end
      R_RESP: begin
        bus.rvalid = 1'b1;
        if (bus.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and register file flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      ctrl_q    <= '0;
      bg_q      <= BG_RST;
      fg_q      <= FG_RST;
      scratch_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      ctrl_q    <= ctrl_d;
      bg_q      <= bg_d;
      fg_q      <= fg_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rresp     = rresp_q;
  assign bus.bresp     = bresp_q;
  assign vga_en_o      = ctrl_q[0];
  assign vga_pattern_o = ctrl_q[1];
  assign vga_bg_o      = bg_q;
  assign vga_fg_o      = fg_q;
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;
endmodule
